// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access; load 3 cycles, store 2, error 1 after acceptance.
// Backpressure: req_ready is high only in IDLE; the memory side has no stall and read data arrives one cycle after mem_ren.
module load_store_unit #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    logic        illegal, misalign, req_bad;
    logic [1:0]  eff_off;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    assign req_ready = (state == IDLE);

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        eff_off  = req_addr[1:0];
        st_mask  = 4'b1111;
        st_data  = req_wdata;
        if (req_we)
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        // funct3[1:0] encodes the access size for both loads and stores
        case (req_funct3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
        req_bad = illegal || (ERR_ON_MISALIGN && misalign);
        if (!ERR_ON_MISALIGN) begin
            if (req_funct3[1:0] == 2'b01)
                eff_off[0] = 1'b0;
            else if (req_funct3[1:0] == 2'b10)
                eff_off = 2'b00;
        end
        case (req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << eff_off;
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {eff_off[1], 1'b0};
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_b   = mem_rdata[8*lat_off +: 8];
        lane_h   = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (lat_funct3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'b0, lane_b};
            3'b101:  load_ext = {16'b0, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_bad ? RESP : ISSUE;
            ISSUE:   state_nxt = lat_we ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            mem_addr   <= 32'b0;
            mem_ren    <= 1'b0;
            mem_wdata  <= 32'b0;
            mem_wmask  <= 4'b0;
        end else begin
            mem_ren    <= 1'b0;
            mem_wmask  <= 4'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_off    <= eff_off;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'b0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_we) begin
                                mem_wmask <= st_mask;
                                mem_wdata <= st_data;
                            end else begin
                                mem_ren <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (lat_we)
                        resp_valid <= 1'b1;
                end
                WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                end
                RESP: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, decoupled monitor on responses and memory strobes.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ERR_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    typedef struct {bit err; logic [31:0] rd; int cyc;} rsp_t;
    typedef struct {logic [31:0] addr; logic [3:0] mask; logic [31:0] data; int cyc;} bus_t;

    rsp_t rsp_q[$];
    bus_t rd_q[$];
    bus_t wr_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int pcyc = 0;

    logic [31:0] mem_w [0:255];
    logic [7:0]  ref_b [0:1023];

    always @(posedge clk) pcyc <= pcyc + 1;

    // Memory seen by the DUT: registered read, byte-masked write.
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_ren) mem_rdata <= mem_w[mem_addr[9:2]];
        w = mem_w[mem_addr[9:2]];
        for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
        if (mem_wmask != 4'b0) mem_w[mem_addr[9:2]] = w;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=event required=none at cycle %0d", name, pcyc);
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    // Reference: access size and sign from funct3, alignment by modulo, bytes in a flat array.
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output bit err, output logic [31:0] rd,
                                  output int sz);
        bit sgn;
        bit legal;
        int base;
        logic [31:0] v;
        sgn = 0; legal = 1; sz = 1; v = 0;
        base = int'(a[9:0]);
        if (we) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin sz = 1; sgn = 1; end
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 4;
                3'd4: sz = 1;
                3'd5: sz = 2;
                default: legal = 0;
            endcase
        end
        err = !legal || ((a % sz) != 0);
        rd = 32'b0;
        if (!err) begin
            for (int k = 0; k < sz; k++) begin
                if (we) ref_b[base + k] = wd[8*k +: 8];
                else    v = v | (32'(ref_b[base + k]) << (8*k));
            end
            if (!we) begin
                if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
                rd = v;
            end
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) unexpected("req_ready_timeout");
        req_valid = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a later idle negedge.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit err;
        logic [31:0] rd;
        int sz, acc, m;
        rsp_t r;
        bus_t b;
        model(we, f3, a, wd, err, rd, sz);
        acc = pcyc + 1;
        r.err = err;
        r.rd  = rd;
        r.cyc = acc + (err ? 0 : (we ? 1 : 2));
        rsp_q.push_back(r);
        if (!err) begin
            b.addr = {a[31:2], 2'b00};
            b.cyc  = acc;
            m = ((1 << sz) - 1) << a[1:0];
            b.mask = m[3:0];
            b.data = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
            if (we) wr_q.push_back(b);
            else    rd_q.push_back(b);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom_range(0, 1));
        req_we = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr = $urandom;
        req_wdata = $urandom;
        wait_idle();
    endtask

    always @(negedge clk) begin
        rsp_t r;
        bus_t b;
        if (resetn) begin
            if (resp_valid) begin
                if (rsp_q.size() == 0) unexpected("resp_valid");
                else begin
                    r = rsp_q.pop_front();
                    chk("resp_err", resp_err, r.err);
                    chk("resp_rdata", resp_rdata, r.rd);
                    chk("resp_cycle", pcyc, r.cyc);
                end
            end
            if (mem_ren) begin
                if (rd_q.size() == 0) unexpected("mem_ren");
                else begin
                    b = rd_q.pop_front();
                    chk("ren_addr", mem_addr, b.addr);
                    chk("ren_cycle", pcyc, b.cyc);
                end
            end
            if (mem_wmask != 4'b0) begin
                if (wr_q.size() == 0) unexpected("mem_wmask");
                else begin
                    b = wr_q.pop_front();
                    chk("wr_addr", mem_addr, b.addr);
                    chk("wr_mask", mem_wmask, b.mask);
                    chk("wr_data", mem_wdata, b.data);
                    chk("wr_cycle", pcyc, b.cyc);
                end
            end
        end
    end

    initial begin
        int diffs;
        for (int i = 0; i < 256; i++) begin
            mem_w[i] = (i == 32'h190 / 4) ? 32'hFF0F0E0D : $urandom;
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = mem_w[i][8*k +: 8];
        end

        #1 resetn = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'b0);
        chk("rst_mem_addr", mem_addr, 32'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'b0);
        chk("rst_mem_wmask", mem_wmask, 4'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        do_req(1'b0, 3'b000, 32'h193, 32'h0);
        do_req(1'b0, 3'b101, 32'h192, 32'h0);
        do_req(1'b0, 3'b001, 32'h192, 32'h0);
        do_req(1'b0, 3'b010, 32'h190, 32'h0);
        do_req(1'b1, 3'b000, 32'h191, 32'h0000_00AB);
        do_req(1'b0, 3'b010, 32'h190, 32'h0);
        do_req(1'b0, 3'b010, 32'h192, 32'h0);
        do_req(1'b0, 3'b011, 32'h190, 32'h0);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        // Store aborted by reset while its write strobe is on the bus.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h190; req_wdata = ~ref_word(32'h190 / 4);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_wmask_before", mem_wmask, 4'hF);
        resetn = 1'b0;
        #1;
        chk("abort_wmask", mem_wmask, 4'b0);
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_mem_word", mem_w[32'h190 / 4], ref_word(32'h190 / 4));

        for (int i = 0; i < 6; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);

        repeat (5) @(negedge clk);
        chk("rsp_q_left", rsp_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (mem_w[i] !== ref_word(i)) diffs++;
        chk("mem_final_diffs", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
